// File: rtl/sd_pio_pkg.sv
// Shared constants for the SD-card bit-banged input PIO family:
// Avalon word addresses and edge-type encodings.
package sd_pio_pkg;

  // Word addresses on the Avalon-MM slave
  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  // Edge types selectable through the EDGE_TYPE parameter
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/sd_dat_in_pio_if.sv
// Avalon-MM slave bus bundle for the SD DAT input PIO.
// The CPU side uses the master modport, the PIO uses the slave modport.
interface sd_dat_in_pio_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );

endinterface

// File: rtl/sd_pio_sync.sv
// WIDTH x STAGES flip-flop synchroniser for asynchronous pad inputs.
// Asynchronous active-low reset clears every stage; q_o is the last stage.
module sd_pio_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  // Stage 0 sits in the low slice; data shifts towards the top slice.
  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  // Shift the pad sample one stage deeper every clock
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/sd_dat_in_pio.sv
// SD DAT[3:0] input PIO: synchronised level read, per-bit edge capture
// with write-1-to-clear, and an optional level interrupt.
// Build option: define SD_DAT_IN_PIO_IRQ_EN to implement irqmask and irq;
// otherwise address 2 reads 0, writes to it are ignored and irq is 0.
module sd_dat_in_pio
  import sd_pio_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_FALL
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  sd_dat_in_pio_if.slave   bus
);

  // Warm-up length; SYNC_STAGES is at most 4 so 3 bits always suffice.
  localparam logic [2:0] WARM_MAX = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] edge_raw;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] clr_bits;
  logic [WIDTH-1:0] wr_bits;
  logic [WIDTH-1:0] edgecap_q;
  logic [WIDTH-1:0] edgecap_d;
  logic [WIDTH-1:0] irqmask_q;
  logic [2:0]       warm_q;
  logic             warm_done;
  logic             irq_q;
  logic             wr_en;
  logic [31:0]      rd_data;
  logic             unused_wdata;

  sd_pio_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (in_port),
    .q_o     (sync_q)
  );

  assign wr_en   = bus.chipselect & ~bus.write_n;
  assign wr_bits = bus.writedata[WIDTH-1:0];
  // Bits above WIDTH are deliberately ignored.
  assign unused_wdata = ^bus.writedata;

  // Select the edge polarity once at elaboration time
  generate
    if (EDGE_TYPE == EDGE_RISE) begin : g_rise
      assign edge_raw = sync_q & ~prev_q;
    end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
      assign edge_raw = ~sync_q & prev_q;
    end else begin : g_any
      assign edge_raw = sync_q ^ prev_q;
    end
  endgenerate

  // Suppress edges until the synchroniser and prev register hold real
  // pad data, so lines already high at reset do not look like edges.
  assign warm_done = (warm_q == WARM_MAX);
  assign edge_hit  = warm_done ? edge_raw : '0;

  // Write-1-to-clear; a new edge on the same bit overrides the clear.
  assign clr_bits  = (wr_en && (bus.address == PIO_ADDR_EDGECAP)) ? wr_bits : '0;
  assign edgecap_d = (edgecap_q & ~clr_bits) | edge_hit;

  // Warm-up counter, previous-sample register and edge capture state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warm_q    <= '0;
      prev_q    <= '0;
      edgecap_q <= '0;
    end else begin
      if (!warm_done) begin
        warm_q <= warm_q + 3'd1;
      end
      prev_q    <= sync_q;
      edgecap_q <= edgecap_d;
    end
  end

`ifdef SD_DAT_IN_PIO_IRQ_EN
  // Interrupt mask register and registered level interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      if (wr_en && (bus.address == PIO_ADDR_IRQMASK)) begin
        irqmask_q <= wr_bits;
      end
      irq_q <= |(edgecap_q & irqmask_q);
    end
  end
`else
  assign irqmask_q = '0;
  assign irq_q     = 1'b0;
`endif

  // Zero-wait-state read mux, zero-extended above WIDTH
  always_comb begin
    rd_data = '0;
    case (bus.address)
      PIO_ADDR_DATA:    rd_data[WIDTH-1:0] = sync_q;
      PIO_ADDR_IRQMASK: rd_data[WIDTH-1:0] = irqmask_q;
      PIO_ADDR_EDGECAP: rd_data[WIDTH-1:0] = edgecap_q;
      default:          rd_data = '0;
    endcase
  end

  assign bus.readdata = rd_data;
  assign bus.irq      = irq_q;

endmodule

// File: tb/tb_sd_dat_in_pio.sv
// Self-checking bench for sd_dat_in_pio (WIDTH 4, SYNC_STAGES 2, falling edge).
// Reference model: a short history of pad samples gives the visible data
// word; edges, captures, mask and irq follow from the behavioural rules.
// Honours SD_DAT_IN_PIO_IRQ_EN in the same way as the design.
module tb_sd_dat_in_pio;
  import sd_pio_pkg::*;

  localparam int W  = 4;
  localparam int S  = 2;
  localparam int ET = EDGE_FALL;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic [W-1:0] in_port;

  sd_dat_in_pio_if bus ();

  sd_dat_in_pio #(
    .WIDTH       (W),
    .SYNC_STAGES (S),
    .EDGE_TYPE   (ET)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in_port (in_port),
    .bus     (bus)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0] hist[$];
  int           n_edges;
  logic [W-1:0] m_data, m_prev, m_cap, m_mask;
  logic         m_irq;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] edge_rule(input logic [W-1:0] cur, input logic [W-1:0] old);
    case (ET)
      EDGE_RISE: return cur & ~old;
      EDGE_FALL: return ~cur & old;
      default:   return cur ^ old;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input int a);
    case (a)
      0:       return 32'(m_data);
      2:       return 32'(m_mask);
      3:       return 32'(m_cap);
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_clear();
    hist.delete();
    n_edges = 0;
    m_data  = '0;
    m_prev  = '0;
    m_cap   = '0;
    m_mask  = '0;
    m_irq   = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] v);
    bus.address = a;
    #1;
    v = bus.readdata;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] v;
    for (int a = 0; a < 4; a++) begin
      read_reg(2'(a), v);
      check_val($sformatf("%s_a%0d", tag, a), v, model_read(a));
    end
    check_val({tag, "_irq"}, 32'(bus.irq), 32'(m_irq));
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare
  task automatic tick();
    logic [W-1:0] nd, eg, clr;
    logic         wr;
    @(posedge clk);
    wr = bus.chipselect && !bus.write_n;
    hist.push_back(in_port);
    if (hist.size() > S) void'(hist.pop_front());
    n_edges++;
    nd  = (hist.size() == S) ? hist[0] : '0;
    eg  = (n_edges >= S + 2) ? edge_rule(m_data, m_prev) : '0;
    clr = (wr && bus.address == 2'd3) ? bus.writedata[W-1:0] : '0;
`ifdef SD_DAT_IN_PIO_IRQ_EN
    m_irq = |(m_cap & m_mask);
    if (wr && bus.address == 2'd2) m_mask = bus.writedata[W-1:0];
`else
    m_irq = 1'b0;
`endif
    m_cap  = (m_cap & ~clr) | eg;
    m_prev = m_data;
    m_data = nd;
    #1;
    check_all("cyc");
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      tick();
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    $display("WR addr=%0d data=0x%08h", a, d);
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic do_reset(input int hold);
    reset_n = 1'b0;
    #1;
    model_clear();
    check_all("rst");
    repeat (hold) @(posedge clk);
    #1;
    reset_n = 1'b1;
    $display("RESET released after %0d cycles", hold);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int          found;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 2'd0;
    bus.writedata  = 32'h0;
    in_port        = 4'hF;
    #3;
    do_reset(3);

    // Lines high through reset must not produce a capture
    idle(10);
    read_reg(2'd3, v); check_val("t1_edgecap", v, 32'h0);
    read_reg(2'd0, v); check_val("t1_data", v, 32'hF);
    check_val("t1_irq", 32'(bus.irq), 32'h0);

    // Falling edge on bit 0: data after S cycles, capture one cycle later
    in_port = 4'hE;
    idle(S - 1);
    read_reg(2'd0, v); check_val("t2_data_early", v, 32'hF);
    idle(1);
    read_reg(2'd0, v); check_val("t2_data", v, 32'hE);
    read_reg(2'd3, v); check_val("t2_cap_early", v, 32'h0);
    idle(1);
    read_reg(2'd3, v); check_val("t2_cap", v, 32'h1);

`ifdef SD_DAT_IN_PIO_IRQ_EN
    // irq follows edgecapture & irqmask one cycle later, on set and on clear
    bus_write(2'd2, 32'h1);
    in_port = 4'hF;
    idle(S + 2);
    bus_write(2'd3, 32'hF);
    idle(1);
    read_reg(2'd3, v); check_val("t3_cap_clr", v, 32'h0);
    check_val("t3_irq_idle", 32'(bus.irq), 32'h0);
    in_port = 4'hE;
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      idle(1);
      read_reg(2'd3, v);
      if (v[0]) found = 1;
    end
    check_val("t3_cap_set", 32'(found), 32'h1);
    check_val("t3_irq_same_cycle", 32'(bus.irq), 32'h0);
    idle(1);
    check_val("t3_irq_rise", 32'(bus.irq), 32'h1);
    bus_write(2'd3, 32'h1);
    read_reg(2'd3, v); check_val("t3_cap_w1c", v, 32'h0);
    check_val("t3_irq_hold", 32'(bus.irq), 32'h1);
    idle(1);
    check_val("t3_irq_fall", 32'(bus.irq), 32'h0);
`else
    // Without the interrupt option: mask reads 0 and irq never asserts
    bus_write(2'd2, 32'hF);
    read_reg(2'd2, v); check_val("t6_mask_absent", v, 32'h0);
    in_port = 4'hF;
    idle(S + 2);
    bus_write(2'd3, 32'hF);
    read_reg(2'd3, v); check_val("t6_cap_clr", v, 32'h0);
    in_port = 4'hE;
    idle(S + 1);
    read_reg(2'd3, v); check_val("t6_cap_set", v, 32'h1);
    check_val("t6_irq_zero", 32'(bus.irq), 32'h0);
    idle(1);
    check_val("t6_irq_zero_late", 32'(bus.irq), 32'h0);
`endif

    // Clear and new edge on bit 0 in the same cycle: the edge wins
    in_port = 4'hF;
    idle(S + 2);
    in_port = 4'hE;
    idle(S);
    bus_write(2'd3, 32'h1);
    read_reg(2'd3, v); check_val("t4_edge_wins", v, 32'h1);
    bus_write(2'd3, 32'h0);
    read_reg(2'd3, v); check_val("t4_w0_nop", v, 32'h1);
    bus_write(2'd3, 32'h1);
    read_reg(2'd3, v); check_val("t4_w1c", v, 32'h0);

    // Reset mid-capture, then warm-up with no spurious capture
    in_port = 4'hF;
    idle(S + 2);
    bus_write(2'd3, 32'hF);
    in_port = 4'hA;
    idle(S + 1);
    read_reg(2'd3, v); check_val("t5_cap5", v, 32'h5);
    do_reset(2);
    read_reg(2'd3, v); check_val("t5_cap_rst", v, 32'h0);
    read_reg(2'd0, v); check_val("t5_data_rst", v, 32'h0);
    idle(S + 3);
    read_reg(2'd3, v); check_val("t5_warm_cap", v, 32'h0);
    read_reg(2'd0, v); check_val("t5_warm_data", v, 32'hA);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) < 2) begin
        do_reset(int'($urandom_range(2, 1)));
      end else begin
        if ($urandom_range(2) == 0) in_port = W'($urandom);
        if ($urandom_range(3) == 0) begin
          bus_write(2'($urandom_range(3)), $urandom);
        end else begin
          idle(1);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
